// File: rtl/reset_seq_ctrl.sv
// ---------------------------------------------------------------------------
// reset_seq_ctrl
//
// Reset and clock-enable sequencer for downstream flop blocks. Each reset
// episode walks HOLD -> SETTLE -> RUN:
//   HOLD   : o_sync_reset high, clock enable low, HOLD_CYCLES long once the
//            synchronized external reset is inactive.
//   SETTLE : reset released, clock still gated, SETTLE_CYCLES long.
//   RUN    : clock enabled, o_ready high, until the next reset event.
//
// Reset sources:
//   async_reset_n  : system reset, puts everything back to the power-up state.
//   i_ext_reset_n  : asynchronous external pin, synchronized internally.
//   i_sw_reset_req : software request, sampled on every rising edge.
//
// Ports:
//   clk            in   system clock, rising edge
//   async_reset_n  in   asynchronous active-low system reset
//   i_ext_reset_n  in   asynchronous active-low external reset
//   i_sw_reset_req in   software reset request (each high sample restarts HOLD)
//   o_sync_reset   out  active-high synchronous reset for downstream blocks
//   o_rst_n_sync   out  active-low reset, async assert / sync deassert
//   o_clk_enable   out  downstream clock enable
//   o_ready        out  high only in RUN
//   o_reset_count  out  saturating count of re-entries into HOLD
// ---------------------------------------------------------------------------
module reset_seq_ctrl #(
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       async_reset_n,
    input  logic       i_ext_reset_n,
    input  logic       i_sw_reset_req,
    output logic       o_sync_reset,
    output logic       o_rst_n_sync,
    output logic       o_clk_enable,
    output logic       o_ready,
    output logic [7:0] o_reset_count
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // -----------------------------------------------------------------------
    localparam int MAX_PERIOD = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;

    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("reset_seq_ctrl: HOLD_CYCLES must be >= 1");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("reset_seq_ctrl: SETTLE_CYCLES must be >= 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("reset_seq_ctrl: SYNC_STAGES must be >= 2");
        end
        if ((64'd1 << CNT_W) <= 64'(MAX_PERIOD)) begin : g_bad_cnt
            $error("reset_seq_ctrl: CNT_W too narrow for HOLD/SETTLE periods");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       COUNT_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Reset synchronizer: clears asynchronously, releases SYNC_STAGES edges
    // after async_reset_n deasserts. Deliberately independent of the other
    // reset sources so downstream async-reset flops only see system reset.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_pipe;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_n_sync = rst_pipe[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // External reset synchronizer. Clears to 0 so the external reset reads
    // as asserted until the chain has filled after power-up.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ext_pipe;
    logic                   ext_sync;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            ext_pipe <= '0;
        end else begin
            ext_pipe <= {ext_pipe[SYNC_STAGES-2:0], i_ext_reset_n};
        end
    end

    assign ext_sync = ext_pipe[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Sequencer FSM
    // -----------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             reset_event;
    logic             enter_hold;

    // A low synchronized external reset and a software request are treated
    // identically: both (re)start HOLD with the counter at zero, which is what
    // stretches the hold while either source stays active.
    assign reset_event = !ext_sync || i_sw_reset_req;

    // Only re-entries from SETTLE/RUN are counted; restarts inside HOLD are not.
    assign enter_hold  = reset_event && (state_q != ST_HOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (reset_event) begin
            // Reset events win over any normal progression on the same edge.
            state_d = ST_HOLD;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers. They are loaded from the next-state decode so they
    // track state_q exactly, but come straight off flops: the downstream
    // reset and clock-enable nets never see decode glitches.
    // -----------------------------------------------------------------------
    logic sync_reset_q;
    logic run_q;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync_reset_q <= 1'b1;
            run_q        <= 1'b0;
        end else begin
            sync_reset_q <= (state_d == ST_HOLD);
            run_q        <= (state_d == ST_RUN);
        end
    end

    assign o_sync_reset = sync_reset_q;
    assign o_clk_enable = run_q;
    assign o_ready      = run_q;

    // -----------------------------------------------------------------------
    // Saturating re-entry counter; only the system reset clears it.
    // -----------------------------------------------------------------------
    logic [7:0] reset_count_q;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            reset_count_q <= '0;
        end else if (enter_hold && (reset_count_q != COUNT_MAX)) begin
            reset_count_q <= reset_count_q + 8'd1;
        end
    end

    assign o_reset_count = reset_count_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reset_seq_ctrl
//
// Self-checking bench for reset_seq_ctrl. Every edge is compared against a
// reference model that derives the sequencer phase from "edges since the
// last reset event", plus table-driven and hand-written scenario checks.
// ---------------------------------------------------------------------------
module tb_reset_seq_ctrl;

    localparam int HOLD   = 4;
    localparam int SETTLE = 2;
    localparam int SS     = 2;

    logic       clk = 1'b0;
    logic       async_reset_n;
    logic       i_ext_reset_n;
    logic       i_sw_reset_req;
    logic       o_sync_reset;
    logic       o_rst_n_sync;
    logic       o_clk_enable;
    logic       o_ready;
    logic [7:0] o_reset_count;

    reset_seq_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .SETTLE_CYCLES(SETTLE),
        .SYNC_STAGES  (SS),
        .CNT_W        (8)
    ) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .i_ext_reset_n (i_ext_reset_n),
        .i_sw_reset_req(i_sw_reset_req),
        .o_sync_reset  (o_sync_reset),
        .o_rst_n_sync  (o_rst_n_sync),
        .o_clk_enable  (o_clk_enable),
        .o_ready       (o_ready),
        .o_reset_count (o_reset_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase after edge x is a pure function of d = x - (last event edge):
    // d < HOLD -> HOLD, d < HOLD+SETTLE -> SETTLE, otherwise RUN.
    int m_n;          // edges since async release
    int m_last;       // most recent edge carrying a reset event
    int m_count;      // expected saturating re-entry count
    bit m_ext_hist[$];// ext pin value sampled at edge k stored at index k-1

    function automatic int phase_of(input int x);
        int d;
        d = x - m_last;
        if (d < HOLD)          return 0;
        if (d < HOLD + SETTLE) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_n     = 0;
        m_last  = 0;
        m_count = 0;
        m_ext_hist.delete();
    endtask

    task automatic model_edge(input bit sw, input bit ext);
        int ph_before;
        bit es;
        ph_before = phase_of(m_n);
        m_n++;
        // Synchronized ext seen at edge n is the pin value sampled SS edges earlier.
        es = (m_n > SS) ? m_ext_hist[m_n - SS - 1] : 1'b0;
        m_ext_hist.push_back(ext);
        if (!es || sw) begin
            if (ph_before != 0 && m_count < 255) m_count++;
            m_last = m_n;
        end
    endtask

    task automatic check_model();
        int ph;
        ph = phase_of(m_n);
        chk("m_sync_reset", int'(o_sync_reset), int'(ph == 0));
        chk("m_clk_enable", int'(o_clk_enable), int'(ph == 2));
        chk("m_ready",      int'(o_ready),      int'(ph == 2));
        chk("m_rst_n_sync", int'(o_rst_n_sync), int'(m_n >= SS));
        chk("m_reset_count", int'(o_reset_count), m_count);
    endtask

    // Drive inputs, take one rising edge, advance the model, compare #1 later.
    task automatic apply_edge(input bit sw, input bit ext);
        i_sw_reset_req = sw;
        i_ext_reset_n  = ext;
        @(posedge clk);
        model_edge(sw, ext);
        #1;
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sync_reset"}, int'(o_sync_reset), 1);
        chk({tag, "_rst_n_sync"}, int'(o_rst_n_sync), 0);
        chk({tag, "_clk_enable"}, int'(o_clk_enable), 0);
        chk({tag, "_ready"},      int'(o_ready),      0);
        chk({tag, "_count"},      int'(o_reset_count), 0);
    endtask

    // 3 ns async reset pulse between edges (called #1 after an edge).
    task automatic async_pulse(input string tag);
        #2;
        async_reset_n = 1'b0;
        #1;
        check_reset_values(tag);
        #2;
        async_reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- power-up vector table ----------------
    typedef struct {
        bit sw;
        bit ext;
        bit e_rst_n;
        bit e_sync;
        bit e_en;
        int e_cnt;
    } vec_t;

    vec_t pu_tbl[9];

    task automatic run_powerup_table(input string tag);
        for (int i = 0; i < 9; i++) begin
            apply_edge(pu_tbl[i].sw, pu_tbl[i].ext);
            chk($sformatf("%s_rst_n[e%0d]", tag, i + 1), int'(o_rst_n_sync), int'(pu_tbl[i].e_rst_n));
            chk($sformatf("%s_sync[e%0d]",  tag, i + 1), int'(o_sync_reset), int'(pu_tbl[i].e_sync));
            chk($sformatf("%s_en[e%0d]",    tag, i + 1), int'(o_clk_enable), int'(pu_tbl[i].e_en));
            chk($sformatf("%s_rdy[e%0d]",   tag, i + 1), int'(o_ready),      int'(pu_tbl[i].e_en));
            chk($sformatf("%s_cnt[e%0d]",   tag, i + 1), int'(o_reset_count), pu_tbl[i].e_cnt);
        end
    endtask

    initial begin
        int highs;
        int ext_low_left;
        bit sw;
        bit ext;

        //               sw ext rst_n sync en cnt   (row i = after edge i+1)
        pu_tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        pu_tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        pu_tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        pu_tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        pu_tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        pu_tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        pu_tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        pu_tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        pu_tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0};

        async_reset_n  = 1'b0;
        i_ext_reset_n  = 1'b1;
        i_sw_reset_req = 1'b0;
        model_reset();

        // Reset state while held.
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst_hold");
        async_reset_n = 1'b1;

        // Power-up sequence.
        run_powerup_table("pu");

        // Single-cycle sw request sampled at edge k (i == 0) while in RUN.
        for (int i = 0; i < 8; i++) begin
            apply_edge(i == 0, 1'b1);
            chk($sformatf("swp_sync[k+%0d]", i), int'(o_sync_reset), int'(i <= 3));
            chk($sformatf("swp_en[k+%0d]", i),   int'(o_clk_enable), int'(i >= 6));
            chk($sformatf("swp_rst_n[k+%0d]", i), int'(o_rst_n_sync), 1);
        end
        chk("swp_count", int'(o_reset_count), 1);

        // External reset low for 10 sampled edges while in RUN.
        for (int i = 1; i <= 18; i++) begin
            apply_edge(1'b0, (i <= 10) ? 1'b0 : 1'b1);
            chk($sformatf("ext_sync[f%0d]", i), int'(o_sync_reset), int'(i >= 3 && i <= 15));
            chk($sformatf("ext_en[f%0d]", i),   int'(o_clk_enable), int'(i <= 2 || i >= 18));
        end
        chk("ext_count", int'(o_reset_count), 2);
        chk("ext_rst_n", int'(o_rst_n_sync), 1);

        // sw pulse enters HOLD; a second request at cnt==2 restarts the hold.
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            apply_edge(i == 0 || i == 3, 1'b1);
            highs += int'(o_sync_reset);
        end
        chk("restart_hold_len", highs, 7);
        chk("restart_count", int'(o_reset_count), 3);
        chk("restart_run", int'(o_ready), 1);

        // Drive into SETTLE, then pulse async reset between edges.
        for (int i = 0; i < 5; i++) apply_edge(i == 0, 1'b1);
        chk("settle_sync", int'(o_sync_reset), 0);
        chk("settle_en", int'(o_clk_enable), 0);
        async_pulse("async_mid");
        run_powerup_table("pu2");

        // Randomized stimulus against the model, with occasional async pulses.
        ext_low_left = 0;
        for (int i = 0; i < 1500; i++) begin
            sw = ($urandom_range(0, 15) == 0);
            if (ext_low_left == 0 && $urandom_range(0, 40) == 0)
                ext_low_left = $urandom_range(1, 6);
            ext = (ext_low_left == 0);
            if (ext_low_left > 0) ext_low_left--;
            apply_edge(sw, ext);
            if ($urandom_range(0, 300) == 0) async_pulse("async_rand");
        end

        // Saturation: 300 sw requests, each from RUN.
        async_pulse("async_sat");
        for (int i = 0; i < 10; i++) apply_edge(1'b0, 1'b1);
        for (int r = 0; r < 300; r++) begin
            apply_edge(1'b1, 1'b1);
            for (int j = 0; j < 8; j++) apply_edge(1'b0, 1'b1);
            if (r == 254) chk("sat_at_255", int'(o_reset_count), 255);
        end
        chk("sat_final", int'(o_reset_count), 255);
        chk("sat_ready", int'(o_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
